bcd_cascade_counter: RTL and testbench
======================================

// Module: bcd_cascade_counter
// PURPOSE
//  Parametrised cascade of BCD digit counters with per-digit modulus, up/down mode,
//  synchronous preset and wrap/borrow signalling. Advances one step per detected
//  source event: value change on src, or rising edge of src[0].
//  Generalises the two-digit clock splitter. Used for display time fields (sec/min/hour)
//  and UART-configured preset counters; carry_out chains to the next field.
// PARAMETERS
//  NUM_DIGITS  2          number of BCD digits; digit 0 is least significant
//  DIGIT_MAX   {4'd5,4'd9} packed 4*NUM_DIGITS vector, per-digit max value (0..9), digit 0 in [3:0]
//  SRC_W       6          width of event source bus
//  EVT_MODE    0          0: event = src differs from previous sample; 1: event = rising edge of src[0]
// PORTS
//  clk        in   1             system clock, all logic on posedge
//  resett     in   1             asynchronous active-high reset
//  en         in   1             count enable; 0 holds count, events dropped
//  up_dn      in   1             1: count up, 0: count down
//  src        in   SRC_W         event source (sampled every clk)
//  load_en    in   1             synchronous preset strobe
//  load_val   in   4*NUM_DIGITS  preset value, BCD packed like count
//  count      out  4*NUM_DIGITS  registered BCD count
//  carry_out  out  1             1-cycle pulse on full-chain wrap (up) or borrow (down)
//  at_limit   out  1             registered: count == all-max (up) or all-zero (down)
// BEHAVIOUR
//  - Reset (async): count=0, carry_out=0, at_limit=0 (up_dn unknown at reset), src_q=0, primed=0.
//  - src_q <= src each cycle; primed <= 1 on first clk after reset release. No event while
//    primed==0: first sample after reset never counts.
//  - evt (comb) = primed & en & (EVT_MODE ? (src[0] & ~src_q[0]) : (src != src_q)).
//  - Latency: count updates on the same clk edge where evt is true (0-cycle detect).
//  - Priority per edge: load_en > evt > hold. load_en ignores en.
//  - Load: each digit d takes min(load_val digit, DIGIT_MAX[d]); carry_out=0 on load.
//  - Up step: digit 0 increments; digit k steps only if all lower digits were at their max.
//    A stepping digit at max wraps to 0.
//  - Down step: mirror; a stepping digit at 0 wraps to its DIGIT_MAX; lower digits at 0 propagate borrow.
//  - carry_out=1 for exactly the cycle after an up step from all-max or a down step from all-zero;
//    otherwise 0.
//  - A digit above its max (only reachable via X/upset) wraps to 0 on the next up step and to
//    DIGIT_MAX on the next down step; no lockup.
//  - up_dn change takes effect on the next evt; no extra step.
//  - at_limit recomputed each cycle from the next count and the current up_dn.
//  - Reset mid-operation: all outputs clear immediately, independent of clk.
// STRUCTURE
//  - Shared include clock_defs.vh: BCD_W=4, default DIGIT_MAX sets (SEC_MIN_MAX={4'd5,4'd9},
//    HOUR_MAX={4'd2,4'd3}), EVT_CHANGE/EVT_RISE constants.
//  - Sub-module bcd_digit_cell (one per digit via generate): inputs step, up_dn, load, load_d,
//    max; outputs digit, term (at max/zero). Top holds event detect, ripple-term AND chain,
//    carry_out and at_limit.
// TESTING (NUM_DIGITS=2, DIGIT_MAX={5,9}, EVT_MODE=0)
//  1. Reset; src held 6'h2A on release -> no count; then 10 src changes -> count=8'h10.
//  2. load 8'h59, up, one change -> count=8'h00, carry_out high exactly 1 cycle.
//  3. count 8'h00, up_dn=0, one change -> count=8'h59, carry_out pulse; next -> 8'h58.
//  4. load_en with load_val=8'h37 on the same edge as an event -> 8'h37; next event -> 8'h38.
//  5. load_val=8'h7C -> count=8'h59 (clamped); en=0 plus 5 changes -> still 8'h59.
//  6. resett pulsed between clk edges at 8'h42 -> count=0 before the next edge.
//     EVT_MODE=1 rerun: 3 rising edges of src[0] -> 8'h03.

Source files
------------

// File: rtl/bcd_cascade_counter_pkg.sv
// -----------------------------------------------------------------------------
// bcd_cascade_counter_pkg
// Shared definitions for the BCD cascade counter family: digit width, the
// common per-digit maximum sets used for time fields, event-mode selectors
// and a small clamp helper used when presetting digits.
// -----------------------------------------------------------------------------
package bcd_cascade_counter_pkg;

    localparam int BCD_W = 4;

    // Per-digit maxima, digit 0 in the low nibble.
    localparam logic [7:0] SEC_MIN_MAX = {4'd5, 4'd9};   // 00..59
    localparam logic [7:0] HOUR_MAX    = {4'd2, 4'd3};   // per-digit 2/3

    // Event detection modes.
    localparam int EVT_CHANGE = 0;   // any change of the source bus
    localparam int EVT_RISE   = 1;   // rising edge of src[0]

    // Limit a preset digit to the digit's maximum so loads never create
    // out-of-range digits.
    function automatic logic [BCD_W-1:0] bcd_clamp(
        input logic [BCD_W-1:0] d,
        input logic [BCD_W-1:0] m
    );
        return (d > m) ? m : d;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// -----------------------------------------------------------------------------
// bcd_digit_cell
// One BCD digit of the cascade. Holds its own digit register and exposes the
// terminal flag the top uses to build the ripple carry/borrow chain.
// Ports:
//   clk        in  system clock
//   rst        in  asynchronous active-high reset (digit -> 0)
//   step       in  advance this digit by one in the up_dn direction
//   up_dn      in  1: count up, 0: count down
//   load       in  preset strobe (wins over step)
//   load_d     in  preset digit value (clamped to max)
//   max        in  this digit's maximum value
//   digit      out registered digit value
//   term       out digit is at its terminal value for the current direction
//   digit_next out value the digit takes on the next clock edge
// -----------------------------------------------------------------------------
module bcd_digit_cell
    import bcd_cascade_counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             up_dn,
    input  logic             load,
    input  logic [BCD_W-1:0] load_d,
    input  logic [BCD_W-1:0] max,
    output logic [BCD_W-1:0] digit,
    output logic             term,
    output logic [BCD_W-1:0] digit_next
);

    logic [BCD_W-1:0] digit_reg;

    always_comb begin
        digit_next = digit_reg;
        if (load) begin
            digit_next = bcd_clamp(load_d, max);
        end else if (step) begin
            if (up_dn) begin
                // ">=" so a corrupted over-max digit recovers to 0.
                digit_next = (digit_reg >= max) ? '0 : digit_reg + 4'd1;
            end else begin
                // Over-max digits recover to max rather than decrementing.
                digit_next = ((digit_reg == '0) || (digit_reg > max)) ? max
                                                                      : digit_reg - 4'd1;
            end
        end
    end

    // Terminal means "this digit wraps on its next step": at/above max when
    // counting up, at zero when counting down.
    assign term = up_dn ? (digit_reg >= max) : (digit_reg == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_reg <= '0;
        end else begin
            digit_reg <= digit_next;
        end
    end

    assign digit = digit_reg;

endmodule

// File: rtl/bcd_cascade_counter.sv
// -----------------------------------------------------------------------------
// bcd_cascade_counter
// Cascade of BCD digits with per-digit modulus, up/down counting, synchronous
// preset and a one-cycle wrap/borrow pulse. Steps once per detected source
// event (bus change, or rising edge of src[0]).
// Ports:
//   clk        in  system clock
//   resett     in  asynchronous active-high reset
//   en         in  count enable (events dropped when low; load unaffected)
//   up_dn      in  1: count up, 0: count down
//   src        in  event source bus, sampled every clock
//   load_en    in  synchronous preset strobe (highest priority)
//   load_val   in  preset value, packed BCD like count
//   count      out registered BCD count, digit 0 in the low nibble
//   carry_out  out one-cycle pulse after a full-chain wrap or borrow
//   at_limit   out count is all-max (up) or all-zero (down)
// -----------------------------------------------------------------------------
module bcd_cascade_counter
    import bcd_cascade_counter_pkg::*;
#(
    parameter int                          NUM_DIGITS = 2,
    parameter logic [BCD_W*NUM_DIGITS-1:0] DIGIT_MAX  = SEC_MIN_MAX,
    parameter int                          SRC_W      = 6,
    parameter int                          EVT_MODE   = EVT_CHANGE
)(
    input  logic                          clk,
    input  logic                          resett,
    input  logic                          en,
    input  logic                          up_dn,
    input  logic [SRC_W-1:0]              src,
    input  logic                          load_en,
    input  logic [BCD_W*NUM_DIGITS-1:0]   load_val,
    output logic [BCD_W*NUM_DIGITS-1:0]   count,
    output logic                          carry_out,
    output logic                          at_limit
);

    logic [SRC_W-1:0]            src_q_reg;
    logic                        primed_reg;
    logic                        carry_reg;
    logic                        at_limit_reg;
    logic                        evt;
    logic [NUM_DIGITS-1:0]       step;
    logic [NUM_DIGITS-1:0]       term;
    logic [BCD_W*NUM_DIGITS-1:0] count_next;
    logic                        chain_wrap;
    logic                        at_limit_next;

    // primed masks the first sample after reset, whose comparison against
    // the cleared src_q would otherwise look like an event.
    assign evt = primed_reg & en &
                 ((EVT_MODE == EVT_RISE) ? (src[0] & ~src_q_reg[0])
                                         : (src != src_q_reg));

    // Digit k steps when the event arrives and every lower digit is terminal.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                assign step[gi] = evt;
            end else begin : g_upper
                assign step[gi] = evt & (&term[gi-1:0]);
            end

            bcd_digit_cell u_cell (
                .clk        (clk),
                .rst        (resett),
                .step       (step[gi]),
                .up_dn      (up_dn),
                .load       (load_en),
                .load_d     (load_val[gi*BCD_W +: BCD_W]),
                .max        (DIGIT_MAX[gi*BCD_W +: BCD_W]),
                .digit      (count[gi*BCD_W +: BCD_W]),
                .term       (term[gi]),
                .digit_next (count_next[gi*BCD_W +: BCD_W])
            );
        end
    endgenerate

    // Whole chain terminal on an event: the counter wraps (up) or borrows (down).
    assign chain_wrap = evt & (&term);

    assign at_limit_next = up_dn ? (count_next == DIGIT_MAX) : (count_next == '0);

    always_ff @(posedge clk or posedge resett) begin
        if (resett) begin
            src_q_reg    <= '0;
            primed_reg   <= 1'b0;
            carry_reg    <= 1'b0;
            at_limit_reg <= 1'b0;
        end else begin
            src_q_reg    <= src;
            primed_reg   <= 1'b1;
            carry_reg    <= load_en ? 1'b0 : chain_wrap;
            at_limit_reg <= at_limit_next;
        end
    end

    assign carry_out = carry_reg;
    assign at_limit  = at_limit_reg;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_cascade_counter
// Drives a change-mode and a rising-edge-mode counter (2 digits, max 59) with
// shared stimulus. A value-domain model (0..59 integer) predicts each cycle's
// outputs; predictions are queued at drive time and popped after the edge.
// -----------------------------------------------------------------------------
module tb_bcd_cascade_counter;
    import bcd_cascade_counter_pkg::*;

    logic       clk = 1'b0;
    logic       resett;
    logic       en;
    logic       up_dn;
    logic [5:0] src;
    logic       load_en;
    logic [7:0] load_val;
    logic [7:0] count0, count1;
    logic       carry_out0, carry_out1;
    logic       at_limit0, at_limit1;

    always #5 clk = ~clk;

    bcd_cascade_counter #(
        .NUM_DIGITS(2), .DIGIT_MAX(SEC_MIN_MAX), .SRC_W(6), .EVT_MODE(EVT_CHANGE)
    ) dut_chg (
        .clk(clk), .resett(resett), .en(en), .up_dn(up_dn), .src(src),
        .load_en(load_en), .load_val(load_val),
        .count(count0), .carry_out(carry_out0), .at_limit(at_limit0)
    );

    bcd_cascade_counter #(
        .NUM_DIGITS(2), .DIGIT_MAX(SEC_MIN_MAX), .SRC_W(6), .EVT_MODE(EVT_RISE)
    ) dut_rise (
        .clk(clk), .resett(resett), .en(en), .up_dn(up_dn), .src(src),
        .load_en(load_en), .load_val(load_val),
        .count(count1), .carry_out(carry_out1), .at_limit(at_limit1)
    );

    typedef struct {
        logic [7:0] c0; logic k0; logic a0;
        logic [7:0] c1; logic k1; logic a1;
    } exp_t;

    exp_t       sb_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         m_v[2];
    logic       m_primed;
    logic [5:0] m_srcq;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp_v);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic model_reset();
        m_v[0]   = 0;
        m_v[1]   = 0;
        m_primed = 1'b0;
        m_srcq   = '0;
    endtask

    task automatic step_cycle(input logic e, input logic ud, input logic [5:0] s,
                              input logic ld, input logic [7:0] lv);
        exp_t x;
        logic ev[2];
        logic cy[2];
        int   t, o;
        en = e; up_dn = ud; src = s; load_en = ld; load_val = lv;
        ev[0] = m_primed && e && (s != m_srcq);
        ev[1] = m_primed && e && s[0] && !m_srcq[0];
        for (int k = 0; k < 2; k++) begin
            cy[k] = 1'b0;
            if (ld) begin
                t = int'(lv[7:4]); o = int'(lv[3:0]);
                if (t > 5) t = 5;
                if (o > 9) o = 9;
                m_v[k] = t * 10 + o;
            end else if (ev[k]) begin
                if (ud) begin
                    cy[k]  = (m_v[k] == 59);
                    m_v[k] = (m_v[k] + 1) % 60;
                end else begin
                    cy[k]  = (m_v[k] == 0);
                    m_v[k] = (m_v[k] + 59) % 60;
                end
            end
        end
        x.c0 = to_bcd(m_v[0]); x.k0 = cy[0]; x.a0 = ud ? (m_v[0] == 59) : (m_v[0] == 0);
        x.c1 = to_bcd(m_v[1]); x.k1 = cy[1]; x.a1 = ud ? (m_v[1] == 59) : (m_v[1] == 0);
        m_srcq   = s;
        m_primed = 1'b1;
        sb_q.push_back(x);

        @(posedge clk);
        #1;
        cyc++;
        if (sb_q.size() == 0) begin
            check("sb_empty", 8'd1, 8'd0);
        end else begin
            x = sb_q.pop_front();
            check("chg_count", count0, x.c0);
            check("chg_carry", 8'(carry_out0), 8'(x.k0));
            check("chg_limit", 8'(at_limit0), 8'(x.a0));
            check("rise_count", count1, x.c1);
            check("rise_carry", 8'(carry_out1), 8'(x.k1));
            check("rise_limit", 8'(at_limit1), 8'(x.a1));
        end
        $display("cyc %0d en=%b up=%b src=%h ld=%b lv=%h | chg=%h c=%b l=%b | rise=%h c=%b l=%b",
                 cyc, e, ud, s, ld, lv, count0, carry_out0, at_limit0,
                 count1, carry_out1, at_limit1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resett = 1'b1; en = 1'b0; up_dn = 1'b1; src = 6'h2A;
        load_en = 1'b0; load_val = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count0, 8'h00);
        check("rst_carry", 8'(carry_out0), 8'h00);
        check("rst_limit", 8'(at_limit0), 8'h00);
        check("rst_count_rise", count1, 8'h00);
        resett = 1'b0;

        // 1: first sample after release never counts, then 10 changes.
        step_cycle(1'b1, 1'b1, 6'h2A, 1'b0, 8'h00);
        check("t1_first_sample", count0, 8'h00);
        step_cycle(1'b1, 1'b1, 6'h2A, 1'b0, 8'h00);
        for (int i = 1; i <= 10; i++) step_cycle(1'b1, 1'b1, 6'(i), 1'b0, 8'h00);
        check("t1_count", count0, 8'h10);
        check("t1_count_rise", count1, 8'h05);

        // 2: wrap from 59 upward.
        step_cycle(1'b1, 1'b1, 6'd10, 1'b1, 8'h59);
        check("t2_load", count0, 8'h59);
        check("t2_limit_up", 8'(at_limit0), 8'h01);
        step_cycle(1'b1, 1'b1, 6'd11, 1'b0, 8'h00);
        check("t2_wrap", count0, 8'h00);
        check("t2_carry", 8'(carry_out0), 8'h01);
        step_cycle(1'b1, 1'b1, 6'd11, 1'b0, 8'h00);
        check("t2_carry_clear", 8'(carry_out0), 8'h00);

        // 3: borrow from 00 downward.
        step_cycle(1'b1, 1'b0, 6'd12, 1'b0, 8'h00);
        check("t3_borrow", count0, 8'h59);
        check("t3_carry", 8'(carry_out0), 8'h01);
        step_cycle(1'b1, 1'b0, 6'd13, 1'b0, 8'h00);
        check("t3_down", count0, 8'h58);
        check("t3_carry_clear", 8'(carry_out0), 8'h00);

        // 4: load beats a coincident event.
        step_cycle(1'b1, 1'b1, 6'd14, 1'b1, 8'h37);
        check("t4_load_prio", count0, 8'h37);
        step_cycle(1'b1, 1'b1, 6'd15, 1'b0, 8'h00);
        check("t4_after", count0, 8'h38);

        // 5: clamped load, then events ignored while disabled.
        step_cycle(1'b1, 1'b1, 6'd15, 1'b1, 8'h7C);
        check("t5_clamp", count0, 8'h59);
        for (int i = 0; i < 5; i++) step_cycle(1'b0, 1'b1, 6'(20 + i), 1'b0, 8'h00);
        check("t5_hold", count0, 8'h59);

        // 6: asynchronous reset between edges.
        step_cycle(1'b1, 1'b1, 6'd24, 1'b1, 8'h42);
        check("t6_preload", count0, 8'h42);
        #2 resett = 1'b1;
        model_reset();
        #1;
        check("t6_async_count", count0, 8'h00);
        check("t6_async_rise", count1, 8'h00);
        check("t6_async_limit", 8'(at_limit0), 8'h00);
        #1 resett = 1'b0;

        // Rising-edge mode: three rises of src[0] (five bus changes).
        step_cycle(1'b1, 1'b1, 6'h00, 1'b0, 8'h00);
        step_cycle(1'b1, 1'b1, 6'h01, 1'b0, 8'h00);
        step_cycle(1'b1, 1'b1, 6'h00, 1'b0, 8'h00);
        step_cycle(1'b1, 1'b1, 6'h01, 1'b0, 8'h00);
        step_cycle(1'b1, 1'b1, 6'h00, 1'b0, 8'h00);
        step_cycle(1'b1, 1'b1, 6'h01, 1'b0, 8'h00);
        check("rise_three", count1, 8'h03);
        check("chg_five", count0, 8'h05);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
